// File: rtl/acs_pm_node.sv
// acs_pm_node
//   Add-compare-select node with path-metric register for one trellis state of
//   a hard-decision Viterbi decoder. Adds the 2-bit branch metrics to the two
//   predecessor path metrics (saturating), keeps the smaller sum (ties go to A),
//   optionally normalises it, registers it, and packs the per-step decision bits
//   into words for the traceback memory.
//
// Ports
//   clk            in   1      clock, rising edge
//   rst            in   1      synchronous reset, active high (priority over start)
//   start          in   1      frame start: reload start metric, clear packer
//   in_valid       in   1      pm_a/pm_b/bm_a/bm_b valid this cycle
//   pm_a, pm_b     in   PM_W   predecessor path metrics
//   bm_a, bm_b     in   2      branch metrics (0..2)
//   norm_en        in   1      subtract NORM_VAL (floored at 0) on this step
//   pm_out         out  PM_W   registered surviving path metric
//   dec_out        out  1      registered decision (0 = A, 1 = B)
//   out_valid      out  1      pm_out/dec_out updated this cycle
//   dec_word       out  DEC_W  packed decisions, bit 0 = oldest
//   dec_word_valid out  1      one-cycle pulse: dec_word complete
module acs_pm_node #(
  parameter int PM_W       = 8,
  parameter int DEC_W      = 8,
  parameter int ZERO_STATE = 0,
  parameter int INIT_PM    = 64,
  parameter int NORM_VAL   = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [PM_W-1:0]  pm_a,
  input  logic [PM_W-1:0]  pm_b,
  input  logic [1:0]       bm_a,
  input  logic [1:0]       bm_b,
  input  logic             norm_en,
  output logic [PM_W-1:0]  pm_out,
  output logic             dec_out,
  output logic             out_valid,
  output logic [DEC_W-1:0] dec_word,
  output logic             dec_word_valid
);

  localparam int CNT_W = (DEC_W > 1) ? $clog2(DEC_W) : 1;
  localparam logic [PM_W-1:0]  START_PM = (ZERO_STATE != 0) ? '0 : PM_W'(INIT_PM);
  localparam logic [PM_W-1:0]  NORM     = PM_W'(NORM_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEC_W - 1);

  logic [PM_W:0]      raw_a, raw_b;
  logic [PM_W-1:0]    sum_a, sum_b, sum_sel, pm_next;
  logic               sel;
  logic [CNT_W-1:0]   count;
  logic [DEC_W-1:0]   part;
  logic [DEC_W-1:0]   word_next;

  always_comb begin
    raw_a = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
    raw_b = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
    // Saturate the carry-out back into range before comparing, so two
    // overflowing sums compare equal and fall to branch A.
    sum_a = raw_a[PM_W] ? '1 : raw_a[PM_W-1:0];
    sum_b = raw_b[PM_W] ? '1 : raw_b[PM_W-1:0];
    sel   = (sum_b < sum_a);
    sum_sel = sel ? sum_b : sum_a;
    if (norm_en)
      pm_next = (sum_sel >= NORM) ? (sum_sel - NORM) : '0;
    else
      pm_next = sum_sel;
    word_next        = part;
    word_next[count] = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_out         <= START_PM;
      dec_out        <= 1'b0;
      out_valid      <= 1'b0;
      dec_word       <= '0;
      dec_word_valid <= 1'b0;
      count          <= '0;
      part           <= '0;
    end else if (start) begin
      pm_out         <= START_PM;
      dec_out        <= 1'b0;
      out_valid      <= 1'b0;
      dec_word       <= '0;
      dec_word_valid <= 1'b0;
      count          <= '0;
      part           <= '0;
    end else if (in_valid) begin
      pm_out    <= pm_next;
      dec_out   <= sel;
      out_valid <= 1'b1;
      if (count == LAST_CNT) begin
        dec_word       <= word_next;
        dec_word_valid <= 1'b1;
        count          <= '0;
        part           <= '0;
      end else begin
        dec_word_valid <= 1'b0;
        count          <= count + CNT_W'(1);
        part           <= word_next;
      end
    end else begin
      out_valid      <= 1'b0;
      dec_word_valid <= 1'b0;
    end
  end

endmodule
